// File: rtl/game_pkg.sv
// game_pkg: shared FSM state type, default parameters and index-width helper for stage_chain_engine
package game_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_SCORE_W = 7;
  localparam int DEF_BONUS_W = 2;
  localparam int DEF_MAX_SCORE = 100;
  localparam int DEF_BONUS_DIV_LOG2 = 5;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stage_chain_engine_stage_eval.sv
// stage_eval: combinational clamp/total/score/pass/bonus of one stage beat (work, hard, luck, carry -> pass, bonus)
module stage_eval #(
  parameter int SCORE_W = 7,
  parameter int BONUS_W = 2,
  parameter int MAX_SCORE = 100,
  parameter int BONUS_DIV_LOG2 = 5
) (
  input  logic [SCORE_W-1:0] work,
  input  logic [SCORE_W-1:0] hard,
  input  logic [BONUS_W-1:0] luck,
  input  logic [BONUS_W-1:0] carry,
  output logic               pass,
  output logic [BONUS_W-1:0] bonus
);
  localparam int TW = SCORE_W + 1;
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_SCORE);
  localparam logic [TW-1:0] BMAX_T = TW'((1 << BONUS_W) - 1);
  logic [SCORE_W-1:0] w_c, h_c;
  logic [TW-1:0] total, score, shr;
  always_comb begin
    w_c = (work > MAX_S) ? MAX_S : work;
    h_c = (hard > MAX_S) ? MAX_S : hard;
    total = TW'(w_c) + (TW'(carry) << 2) + (TW'(luck) << 2);
    score = (total > MAX_T) ? MAX_T : total;
    pass = score > TW'(h_c);
    shr = total >> BONUS_DIV_LOG2;
    bonus = !pass ? '0 : (shr > BMAX_T) ? BMAX_T[BONUS_W-1:0] : shr[BONUS_W-1:0];
  end
endmodule

// File: rtl/stage_chain_engine.sv
// stage_chain_engine: chains NUM_STAGES stage evaluations per game (start/in_valid/in_ready beats in; res_* per stage, done/win/final_bonus verdict out; GAME_RETRY_EN grants one retry per game)
module stage_chain_engine
  import game_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int BONUS_W = DEF_BONUS_W,
  parameter int MAX_SCORE = DEF_MAX_SCORE,
  parameter int BONUS_DIV_LOG2 = DEF_BONUS_DIV_LOG2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SCORE_W-1:0]               work,
  input  logic [SCORE_W-1:0]               hard,
  input  logic [BONUS_W-1:0]               luck,
  output logic                             busy,
  output logic                             res_valid,
  output logic [idx_w(NUM_STAGES)-1:0]     res_stage,
  output logic                             res_pass,
  output logic [BONUS_W-1:0]               res_bonus,
  output logic                             done,
  output logic                             win,
  output logic [BONUS_W-1:0]               final_bonus,
  output logic                             retry_used
);
  localparam int IW = idx_w(NUM_STAGES);
  state_t state;
  logic [IW-1:0] idx;
  logic [BONUS_W-1:0] carry, bonus;
  logic pass, accept, last;
  stage_eval #(
    .SCORE_W(SCORE_W), .BONUS_W(BONUS_W), .MAX_SCORE(MAX_SCORE), .BONUS_DIV_LOG2(BONUS_DIV_LOG2)
  ) u_eval (
    .work(work), .hard(hard), .luck(luck), .carry(carry), .pass(pass), .bonus(bonus)
  );
  assign in_ready = state == PLAY;
  assign busy = state == PLAY;
  assign accept = in_valid & in_ready;
  assign last = idx == IW'(NUM_STAGES - 1);
`ifdef GAME_RETRY_EN
  logic retry_q;
  assign retry_used = retry_q;
`else
  assign retry_used = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= '0;
      res_valid <= 1'b0;
      res_stage <= '0;
      res_pass <= 1'b0;
      res_bonus <= '0;
      done <= 1'b0;
      win <= 1'b0;
      final_bonus <= '0;
`ifdef GAME_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      res_valid <= accept;
      done <= 1'b0;
      if (state == IDLE && start) begin
        state <= PLAY;
        idx <= '0;
        carry <= '0;
        win <= 1'b0;
        final_bonus <= '0;
`ifdef GAME_RETRY_EN
        retry_q <= 1'b0;
`endif
      end
      if (accept) begin
        res_stage <= idx;
        res_pass <= pass;
        res_bonus <= bonus;
        if (pass && !last) begin
          idx <= idx + 1'b1;
          carry <= bonus;
        end else if (pass) begin
          win <= 1'b1;
          final_bonus <= bonus;
          done <= 1'b1;
          state <= IDLE;
        end
`ifdef GAME_RETRY_EN
        else if (!retry_q) retry_q <= 1'b1;
`endif
        else begin
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule
